// File: rtl/fetch_pkg.sv
// Shared widths, the prefetch entry layout and the PC increment for the fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode handshake: the fetch side presents {pc, instr} with valid, decode answers ready.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic            instr_valid;
  logic            instr_ready;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] pc;

  modport master (output instr_valid, output instr, output pc, input instr_ready);
  modport slave  (input instr_valid, input instr, input pc, output instr_ready);

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with flush; the head reads as zero when empty and there is no write-to-read bypass.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  entry_t        wdata,
  output entry_t        rdata,
  output logic [CW-1:0] count
);

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // Entry storage; flush leaves the data in place since count gates the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (push && !flush) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; flush outranks any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= PW'(0);
      r_rd_ptr <= PW'(0);
      r_count  <= CW'(0);
    end else if (flush) begin
      r_wr_ptr <= PW'(0);
      r_rd_ptr <= PW'(0);
      r_count  <= CW'(0);
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata = (r_count != CW'(0)) ? r_mem[r_rd_ptr] : '0;
  assign count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, push/halt control and decode-side output mapping.
// Optional build macro FETCH_MISALIGN_EN: misaligned redirect targets halt fetch and raise misalign_o.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [XLEN-1:0]   mem_addr_o,
  input  logic [ILEN-1:0]   mem_data_i,
  input  logic              redirect_valid_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              misalign_o,
  fetch_unit_if.master      instr_if
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] w_fetch_pc_nxt;
  logic [XLEN-1:0] w_redirect_pc;
  logic [CW-1:0]   w_count;
  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_halted;
  fetch_entry_t    w_wdata;
  fetch_entry_t    w_head;

`ifdef FETCH_MISALIGN_EN
  logic r_misalign;

  assign w_redirect_pc = redirect_pc_i;

  // Misaligned redirect latches a halt until an aligned redirect arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (redirect_valid_i) begin
      r_misalign <= (redirect_pc_i[1:0] != 2'b00);
    end else begin
      r_misalign <= r_misalign;
    end
  end

  assign w_halted   = r_misalign;
  assign misalign_o = r_misalign;
`else
  assign w_redirect_pc = redirect_pc_i & ~(XLEN'(32'd3));
  assign w_halted      = 1'b0;
  assign misalign_o    = 1'b0;
`endif

  assign w_valid = (w_count != CW'(0));
  assign w_pop   = w_valid & instr_if.instr_ready;
  assign w_push  = !redirect_valid_i && !w_halted && ((w_count < CW'(DEPTH)) || w_pop);
  assign w_wdata = '{pc: r_fetch_pc, instr: mem_data_i};

  // Next fetch PC: redirect wins, otherwise advance only when a word is captured.
  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    if (redirect_valid_i) begin
      w_fetch_pc_nxt = w_redirect_pc;
    end else if (w_push) begin
      w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
    end else begin
      w_fetch_pc_nxt = r_fetch_pc;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid_i),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wdata),
    .rdata (w_head),
    .count (w_count)
  );

  assign mem_addr_o           = r_fetch_pc;
  assign instr_if.instr_valid = w_valid;
  assign instr_if.instr       = w_head.instr;
  assign instr_if.pc          = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirects, PC wrap and mid-cycle reset.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic            clk;
  logic            rst_n;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_data;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic            misalign;
  int              checks;
  int              errors;

  fetch_unit_if u_if ();

  fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_addr_o       (mem_addr),
    .mem_data_i       (mem_data),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .misalign_o       (misalign),
    .instr_if         (u_if)
  );

  // Mock memory contents: two real instructions at 0x0/0x4, address-tagged words elsewhere.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0000_0000)      return 32'h0000_0013;
    else if (a == 32'h0000_0004) return 32'h0010_0093;
    else                         return 32'h1000_0000 | a;
  endfunction

  assign mem_data = word_at(mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
    chk({tag, "_valid"}, {31'd0, u_if.instr_valid}, 32'd1);
    chk({tag, "_pc"}, u_if.pc, exp_pc);
    chk({tag, "_instr"}, u_if.instr, exp_instr);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    u_if.instr_ready = 1'b1;
    #1;
    chk("rst_valid", {31'd0, u_if.instr_valid}, 32'd0);
    chk("rst_instr", u_if.instr, 32'h0);
    chk("rst_pc", u_if.pc, 32'h0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming with decode always ready.
    tick(); chk_head("s0", 32'h0, 32'h0000_0013);
    tick(); chk_head("s1", 32'h4, 32'h0010_0093);
    tick(); chk_head("s2", 32'h8, 32'h1000_0008);
    chk("s2_addr", mem_addr, 32'hC);

    // Back-pressure: refill from 0 with decode stalled.
    u_if.instr_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick(); chk("bp_flush_valid", {31'd0, u_if.instr_valid}, 32'd0);
    redirect_valid = 1'b0;
    repeat (10) tick();
    chk_head("bp_full", 32'h0, 32'h0000_0013);
    chk("bp_addr_hold", mem_addr, 32'h10);
    u_if.instr_ready = 1'b1;
    tick(); chk_head("bp_d1", 32'h4, 32'h0010_0093);
    tick(); chk_head("bp_d2", 32'h8, 32'h1000_0008);
    tick(); chk_head("bp_d3", 32'hC, 32'h1000_000C);
    tick(); chk_head("bp_d4", 32'h10, 32'h1000_0010);

    // Redirect while full with a coincident handshake.
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick(); chk("rd_valid", {31'd0, u_if.instr_valid}, 32'd0);
    chk("rd_addr", mem_addr, 32'h40);
    redirect_valid = 1'b0; u_if.instr_ready = 1'b0;
    tick(); chk_head("rd_first", 32'h40, 32'h1000_0040);
    tick(); chk_head("rd_stall", 32'h40, 32'h1000_0040);
    u_if.instr_ready = 1'b1;

    // Back-to-back redirects: only the last target is fetched.
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick(); chk("bb_valid0", {31'd0, u_if.instr_valid}, 32'd0);
    redirect_pc = 32'h60;
    tick(); chk("bb_valid1", {31'd0, u_if.instr_valid}, 32'd0);
    chk("bb_addr", mem_addr, 32'h60);
    redirect_valid = 1'b0;
    tick(); chk_head("bb_first", 32'h60, 32'h1000_0060);

    // Misaligned redirect target.
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    tick();
`ifdef FETCH_MISALIGN_EN
    chk("ma_flag", {31'd0, misalign}, 32'd1);
    chk("ma_valid0", {31'd0, u_if.instr_valid}, 32'd0);
    chk("ma_addr", mem_addr, 32'h22);
    redirect_valid = 1'b0;
    tick(); chk("ma_halt_valid", {31'd0, u_if.instr_valid}, 32'd0);
    chk("ma_halt_flag", {31'd0, misalign}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h24;
    tick(); chk("ma_clr_flag", {31'd0, misalign}, 32'd0);
    redirect_valid = 1'b0;
    tick(); chk_head("ma_resume", 32'h24, 32'h1000_0024);
`else
    chk("ma_flag", {31'd0, misalign}, 32'd0);
    chk("ma_valid0", {31'd0, u_if.instr_valid}, 32'd0);
    chk("ma_addr", mem_addr, 32'h20);
    redirect_valid = 1'b0;
    tick(); chk_head("ma_forced", 32'h20, 32'h1000_0020);
    chk("ma_flag1", {31'd0, misalign}, 32'd0);
`endif

    // PC wrap from the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick(); chk_head("wr_top", 32'hFFFF_FFFC, 32'h1000_0000 | 32'hFFFF_FFFC);
    chk("wr_addr", mem_addr, 32'h0);
    tick(); chk_head("wr_zero", 32'h0, 32'h0000_0013);

    // Asynchronous reset mid-cycle with three entries queued.
    u_if.instr_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    chk_head("ar_pre", 32'h80, 32'h1000_0080);
    chk("ar_pre_addr", mem_addr, 32'h8C);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, u_if.instr_valid}, 32'd0);
    chk("ar_instr", u_if.instr, 32'h0);
    chk("ar_pc", u_if.pc, 32'h0);
    chk("ar_addr", mem_addr, 32'h0);
    chk("ar_misalign", {31'd0, misalign}, 32'd0);
    #2 rst_n = 1'b1;
    u_if.instr_ready = 1'b1;
    tick(); chk_head("ar_r0", 32'h0, 32'h0000_0013);
    tick(); chk_head("ar_r1", 32'h4, 32'h0010_0093);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
